// File: rtl/sin_err_monitor.sv
// Error monitor comparing exact and approximate sin_24b outputs over a programmed run.
// Accumulates mismatch count, saturating sum of |exact-approx| and max |exact-approx|.
module sin_err_monitor #(
    parameter int W     = 25,
    parameter int CNT_W = 20,
    parameter int ACC_W = 48
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] n_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     exact,
    input  logic [W-1:0]     approx,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_count,
    output logic [ACC_W-1:0] err_sum,
    output logic [W-1:0]     err_max,
    output logic             sum_sat
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] n_lat, acc_cnt;
    logic [W:0]       diff;
    logic [W-1:0]     mag, d1;
    logic             ne1, v1;
    logic             start_ok, xfer, last;
    logic [ACC_W:0]   sum_ext;

    // The done cycle is already IDLE, so start must be masked there too.
    assign start_ok = (state == S_IDLE) && start && !done;
    assign in_ready = (state == S_RUN);
    assign busy     = (state != S_IDLE);
    assign xfer     = in_valid && in_ready;
    assign last     = xfer && ((acc_cnt + CNT_W'(1)) == n_lat);

    assign diff    = {1'b0, exact} - {1'b0, approx};
    assign mag     = diff[W] ? (~diff[W-1:0] + W'(1)) : diff[W-1:0];
    assign sum_ext = {1'b0, err_sum} + (ACC_W+1)'(d1);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start_ok) state_nx = (n_samples == '0) ? S_DRAIN : S_RUN;
            S_RUN:   if (last) state_nx = S_DRAIN;
            S_DRAIN: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            n_lat     <= '0;
            acc_cnt   <= '0;
            v1        <= 1'b0;
            d1        <= '0;
            ne1       <= 1'b0;
            done      <= 1'b0;
            err_count <= '0;
            err_sum   <= '0;
            err_max   <= '0;
            sum_sat   <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= (state == S_DRAIN);
            v1    <= xfer;
            if (xfer) begin
                d1      <= mag;
                ne1     <= |mag;
                acc_cnt <= acc_cnt + CNT_W'(1);
            end
            // v1 is never set in IDLE, so clear and accumulate cannot collide.
            if (start_ok) begin
                n_lat     <= n_samples;
                acc_cnt   <= '0;
                err_count <= '0;
                err_sum   <= '0;
                err_max   <= '0;
                sum_sat   <= 1'b0;
            end else if (v1) begin
                err_count <= err_count + CNT_W'(ne1);
                if (d1 > err_max) err_max <= d1;
                if (sum_ext[ACC_W]) begin
                    err_sum <= '1;
                    sum_sat <= 1'b1;
                end else begin
                    err_sum <= sum_ext[ACC_W-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_sin_err_monitor.sv
// Bench for sin_err_monitor: default 48-bit accumulator plus a 26-bit instance for saturation.
module tb_sin_err_monitor;

    logic        clk = 0, rst_n = 0, start = 0, in_valid = 0;
    logic [19:0] n_samples = '0;
    logic [24:0] exact = '0, approx = '0;

    logic        rdy, busy, done, sat48, rdy26, busy26, done26, sat26;
    logic [19:0] cnt48, cnt26;
    logic [47:0] sum48;
    logic [25:0] sum26;
    logic [24:0] max48, max26;

    sin_err_monitor dut (.clk(clk), .rst_n(rst_n), .start(start), .n_samples(n_samples),
        .in_valid(in_valid), .in_ready(rdy), .exact(exact), .approx(approx), .busy(busy),
        .done(done), .err_count(cnt48), .err_sum(sum48), .err_max(max48), .sum_sat(sat48));

    sin_err_monitor #(.ACC_W(26)) dut26 (.clk(clk), .rst_n(rst_n), .start(start),
        .n_samples(n_samples), .in_valid(in_valid), .in_ready(rdy26), .exact(exact),
        .approx(approx), .busy(busy26), .done(done26), .err_count(cnt26), .err_sum(sum26),
        .err_max(max26), .sum_sat(sat26));

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    logic [24:0] q_ex[$], q_ap[$];
    longint unsigned m_cnt, m_sum, m_max;

    typedef struct { logic [24:0] ex; logic [24:0] ap; logic [24:0] d; } vec_t;
    vec_t tbl[6];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic chk_results();
        longint unsigned s26 = (m_sum > 64'h3FFFFFF) ? 64'h3FFFFFF : m_sum;
        chk("err_count", 64'(cnt48), m_cnt);
        chk("err_sum48", 64'(sum48), m_sum);
        chk("err_max",   64'(max48), m_max);
        chk("sum_sat48", 64'(sat48), 0);
        chk("err_count26", 64'(cnt26), m_cnt);
        chk("err_sum26", 64'(sum26), s26);
        chk("sum_sat26", 64'(sat26), 64'(m_sum > 64'h3FFFFFF));
    endtask

    task automatic gen_pair(input int dmode);
        if (q_ex.size() > 0) begin
            exact = q_ex.pop_front(); approx = q_ap.pop_front();
        end else begin
            exact = 25'($urandom);
            case (dmode)
                1: approx = exact;
                2: approx = exact ^ 25'($urandom_range(0, 15));
                3: begin exact = 25'h1FFFFFF; approx = '0; end
                default: approx = 25'($urandom);
            endcase
        end
    endtask

    // vmode: 0 always valid, 1 random valid, 2 LSB-first pattern from vpat
    task automatic do_run(input int n, input int vmode, input logic [31:0] vpat,
                          input int dmode, input bit poke);
        int acc = 0, cyc = 0, vi = 0;
        m_cnt = 0; m_sum = 0; m_max = 0;
        @(negedge clk);
        start = 1; n_samples = 20'(n); in_valid = 0;
        @(posedge clk);
        @(negedge clk);
        start = 0;
        chk("busy_after_start", 64'(busy), 1);
        chk("ready_after_start", 64'(rdy), 64'(n != 0));
        chk("cleared_sum", 64'(sum48), 0);
        chk("cleared_sat26", 64'(sat26), 0);
        while (acc < n && cyc < 5000) begin
            case (vmode)
                0: in_valid = 1;
                1: in_valid = ($urandom_range(0, 3) != 0);
                default: begin in_valid = (vi < 32) ? vpat[vi] : 1'b1; vi++; end
            endcase
            gen_pair(dmode);
            start = poke && (acc == 1);
            n_samples = (poke && acc == 1) ? 20'd7 : 20'(n);
            @(posedge clk);
            if (in_valid) begin
                longint unsigned d = (exact > approx) ? 64'(exact - approx) : 64'(approx - exact);
                acc++;
                m_cnt += (d != 0) ? 1 : 0;
                m_sum += d;
                if (d > m_max) m_max = d;
            end
            @(negedge clk);
            cyc++;
            chk("in_ready", 64'(rdy), 64'(acc < n));
        end
        if (cyc >= 5000) chk("run_timeout", 64'(cyc), 0);
        // DRAIN cycle: one more valid pair that must not be counted
        start = poke; in_valid = 1; gen_pair(0);
        chk("drain_done", 64'(done), 0);
        chk("drain_busy", 64'(busy), 1);
        chk("drain_ready", 64'(rdy), 0);
        @(posedge clk);
        @(negedge clk);
        chk("done_pulse", 64'(done), 1);
        chk("done_busy", 64'(busy), 0);
        chk_results();
        start = poke; n_samples = 20'd3; in_valid = 1;
        @(posedge clk);
        @(negedge clk);
        start = 0; in_valid = 0;
        chk("done_low", 64'(done), 0);
        chk("idle_busy", 64'(busy), 0);
        chk("idle_ready", 64'(rdy), 0);
        chk_results();
    endtask

    initial begin
        tbl[0] = '{25'd100, 25'd90, 25'd10};
        tbl[1] = '{25'd90, 25'd100, 25'd10};
        tbl[2] = '{25'h1FFFFFF, 25'd0, 25'h1FFFFFF};
        tbl[3] = '{25'd0, 25'h1FFFFFF, 25'h1FFFFFF};
        tbl[4] = '{25'd5, 25'd5, 25'd0};
        tbl[5] = '{25'h1000000, 25'h0FFFFFF, 25'd1};

        // reset and idle with stray valids
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_ready", 64'(rdy), 0);
        rst_n = 1;
        m_cnt = 0; m_sum = 0; m_max = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; exact = 25'($urandom); approx = 25'($urandom);
            @(posedge clk); @(negedge clk);
            chk("idle_ready", 64'(rdy), 0);
            chk("idle_done", 64'(done), 0);
        end
        in_valid = 0;
        chk_results();

        // single-sample table
        for (int i = 0; i < 6; i++) begin
            q_ex.push_back(tbl[i].ex); q_ap.push_back(tbl[i].ap);
            do_run(1, 0, 0, 0, 0);
            chk("tbl_max", 64'(max48), 64'(tbl[i].d));
            chk("tbl_sum", 64'(sum48), 64'(tbl[i].d));
            chk("tbl_cnt", 64'(cnt48), 64'(tbl[i].d != 0));
        end

        do_run(16, 0, 0, 1, 0);
        chk("match_cnt", 64'(cnt48), 0);
        chk("match_max", 64'(max48), 0);

        for (int i = 0; i < 3; i++) begin q_ex.push_back(tbl[i].ex); q_ap.push_back(tbl[i].ap); end
        do_run(3, 0, 0, 0, 0);
        chk("sd_cnt", 64'(cnt48), 3);
        chk("sd_sum", 64'(sum48), 64'h2000013);
        chk("sd_max", 64'(max48), 64'h1FFFFFF);

        do_run(4, 2, 32'b1101101, 0, 1);
        chk("bub_cnt_bound", 64'(cnt48 <= 4), 1);

        do_run(0, 0, 0, 0, 0);
        chk("zero_cnt", 64'(cnt48), 0);

        do_run(3, 0, 0, 3, 0);
        chk("sat_sum26", 64'(sum26), 64'h3FFFFFF);
        chk("sat_flag26", 64'(sat26), 1);
        chk("nosat_sum48", 64'(sum48), 64'h5FFFFFD);
        repeat (5) @(negedge clk);
        chk("sat_hold", 64'(sat26), 1);
        chk("sat_sum_hold", 64'(sum26), 64'h3FFFFFF);
        do_run(2, 0, 0, 1, 0);

        for (int r = 0; r < 10; r++)
            do_run($urandom_range(1, 40), $urandom_range(0, 1), 0, $urandom_range(0, 2), bit'(r & 1));

        // abort mid-run
        @(negedge clk);
        start = 1; n_samples = 20'd100;
        @(posedge clk); @(negedge clk);
        start = 0; in_valid = 1;
        for (int i = 0; i < 50; i++) begin
            exact = 25'($urandom); approx = 25'($urandom);
            @(posedge clk); @(negedge clk);
        end
        in_valid = 0;
        rst_n = 0;
        #1;
        m_cnt = 0; m_sum = 0; m_max = 0;
        chk("abort_busy", 64'(busy), 0);
        chk("abort_ready", 64'(rdy), 0);
        chk("abort_done", 64'(done), 0);
        chk_results();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 2) rst_n = 1;
            chk("abort_nodone", 64'(done), 0);
        end
        do_run(7, 1, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
